// File: rtl/muldiv_unit_pkg.sv
// riscv_m_pkg: shared RV32M multiply/divide definitions.
//   XLEN           operand/result width (32 only)
//   F3_*           funct3 operation encodings
//   MULDIV_LATENCY start-to-done cycle count
//   state_t        iterative unit FSM states
package riscv_m_pkg;
    localparam int XLEN = 32;
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;
    localparam int MULDIV_LATENCY = 33;
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: issue/result bundle between the execute stage and the muldiv unit.
//   start   request, sampled only while the unit is idle
//   funct3  RV32M operation select
//   opA     rs1 value
//   opB     rs2 value
//   busy    operation in flight
//   done    one-cycle pulse, result valid
//   result  registered result, held until the next done
interface muldiv_unit_if;
    import riscv_m_pkg::*;
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] opA;
    logic [XLEN-1:0] opB;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    modport master (output start, funct3, opA, opB, input busy, done, result);
    modport slave  (input start, funct3, opA, opB, output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, fixed 33-cycle latency.
//   clk  rising-edge clock
//   rst  synchronous active-low reset
//   bus  slave side of muldiv_unit_if (start/funct3/opA/opB in, busy/done/result out)
module muldiv_unit
    import riscv_m_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    muldiv_unit_if.slave   bus
);
    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_cnt;
    logic [2:0]  r_f3;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_opa;
    logic        r_sa;
    logic        r_neg;
    logic        r_div0;
    // Shared working register: multiply keeps {partial product, multiplier},
    // divide keeps {partial remainder, dividend/quotient}.
    logic [63:0] r_acc;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_result;
    logic        w_sa_in;
    logic        w_sb_in;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_sum;
    logic [63:0] w_mul_next;
    logic [32:0] w_rem_sh;
    logic        w_ge;
    logic [31:0] w_diff;
    logic [63:0] w_div_next;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_res;

    assign w_sa_in = bus.opA[31] & (bus.funct3 == F3_MULH || bus.funct3 == F3_MULHSU ||
                                    bus.funct3 == F3_DIV  || bus.funct3 == F3_REM);
    assign w_sb_in = bus.opB[31] & (bus.funct3 == F3_MULH || bus.funct3 == F3_DIV ||
                                    bus.funct3 == F3_REM);
    assign w_mag_a = w_sa_in ? -bus.opA : bus.opA;
    assign w_mag_b = w_sb_in ? -bus.opB : bus.opB;

    // Shift-add step: add multiplicand to the upper half when the multiplier LSB is set.
    assign w_sum      = {1'b0, r_acc[63:32]} + {1'b0, r_a};
    assign w_mul_next = r_acc[0] ? {w_sum, r_acc[31:1]} : {1'b0, r_acc[63:1]};

    // Restoring step: the 33-bit shifted remainder is compared against the divisor;
    // when it fits, the true difference is below 2^32, so a 32-bit subtract is exact.
    assign w_rem_sh   = {r_acc[63:32], r_acc[31]};
    assign w_ge       = w_rem_sh >= {1'b0, r_b};
    assign w_diff     = w_rem_sh[31:0] - r_b;
    assign w_div_next = {w_ge ? w_diff : w_rem_sh[31:0], r_acc[30:0], w_ge};

    // Divide-by-zero results override the sign fix-up.
    assign w_prod = r_neg ? -r_acc : r_acc;
    assign w_quo  = r_div0 ? 32'hFFFF_FFFF : (r_neg ? -r_acc[31:0] : r_acc[31:0]);
    assign w_rem  = r_div0 ? r_opa : (r_sa ? -r_acc[63:32] : r_acc[63:32]);
    assign w_res  = !r_f3[2] ? (r_f3[1:0] == 2'b00 ? w_prod[31:0] : w_prod[63:32])
                             : (r_f3[1] ? w_rem : w_quo);

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.start ? CALC : IDLE;
            CALC:    w_next = r_cnt == 5'd31 ? FIX : CALC;
            FIX:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_cnt    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (bus.start) begin
                    r_f3   <= bus.funct3;
                    r_a    <= w_mag_a;
                    r_b    <= w_mag_b;
                    r_opa  <= bus.opA;
                    r_sa   <= w_sa_in;
                    r_neg  <= w_sa_in ^ w_sb_in;
                    r_div0 <= bus.funct3[2] && bus.opB == '0;
                    r_acc  <= {32'b0, bus.funct3[2] ? w_mag_a : w_mag_b};
                    r_cnt  <= '0;
                    r_busy <= 1'b1;
                end
                CALC: begin
                    r_acc <= r_f3[2] ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 5'd1;
                end
                FIX: begin
                    r_result <= w_res;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit with a result scoreboard.
module tb_muldiv_unit;
    import riscv_m_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    muldiv_unit_if bus();
    muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents a request for one edge, then scrambles the operands so that
    // only the values sampled at that edge can influence the result.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.funct3 = f3;
        bus.opA = a;
        bus.opB = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.opA = $urandom;
        bus.opB = $urandom;
        bus.funct3 = 3'($urandom);
    endtask

    task automatic wait_result(input string tag, input int elapsed);
        int n = elapsed;
        bit busy_ok = (elapsed != 0) || bus.busy;
        logic [31:0] exp;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done) break;
            if (!bus.busy) busy_ok = 1'b0;
        end
        chk({tag, " latency"}, 32'(n), 32'(MULDIV_LATENCY));
        chk({tag, " busy"}, {31'b0, busy_ok && !bus.busy}, 32'd1);
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        chk(tag, bus.result, exp);
    endtask

    task automatic op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
        sb.push_back(exp);
        issue(f3, a, b);
        wait_result(tag, 0);
        @(posedge clk);
        #1;
        chk({tag, " done pulse"}, {31'b0, bus.done}, 32'd0);
        chk({tag, " hold"}, bus.result, exp);
    endtask

    initial begin
        bit seen;
        bus.start = 1'b0;
        bus.funct3 = '0;
        bus.opA = '0;
        bus.opB = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", {31'b0, bus.busy}, 32'd0);
        chk("reset done", {31'b0, bus.done}, 32'd0);
        chk("reset result", bus.result, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        op("mul", F3_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        op("mulh", F3_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        op("mulhu", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        op("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        op("div", F3_DIV, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFA);
        op("rem", F3_REM, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFE);
        op("divu", F3_DIVU, 32'h0000_0014, 32'h0000_0003, 32'h0000_0006);
        op("remu", F3_REMU, 32'h0000_0014, 32'h0000_0003, 32'h0000_0002);
        op("div0", F3_DIV, 32'h0000_0014, 32'h0000_0000, 32'hFFFF_FFFF);
        op("rem0", F3_REM, 32'h0000_0014, 32'h0000_0000, 32'h0000_0014);
        op("divu0", F3_DIVU, 32'hFFFF_FFEC, 32'h0000_0000, 32'hFFFF_FFFF);
        op("div0 neg", F3_DIV, 32'hFFFF_FFEC, 32'h0000_0000, 32'hFFFF_FFFF);
        op("rem0 neg", F3_REM, 32'hFFFF_FFEC, 32'h0000_0000, 32'hFFFF_FFEC);
        op("div ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        op("rem ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        op("rem pos/neg", F3_REM, 32'h0000_0014, 32'hFFFF_FFFD, 32'h0000_0002);

        sb.push_back(32'd14);
        issue(F3_DIVU, 32'd100, 32'd7);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        bus.start = 1'b1;
        bus.funct3 = F3_MUL;
        bus.opA = 32'd9;
        bus.opB = 32'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_result("ignored start", 5);
        @(posedge clk);
        #1;
        chk("ignored start idle", {31'b0, bus.busy | bus.done}, 32'd0);

        sb.push_back(32'd2);
        issue(F3_REMU, 32'd100, 32'd7);
        wait_result("b2b first", 0);
        sb.push_back(32'd3);
        issue(F3_MULHU, 32'h0001_0000, 32'h0003_0000);
        wait_result("b2b second", 0);
        @(posedge clk);
        #1;

        issue(F3_DIV, 32'hFFFF_FFEC, 32'h0000_0003);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort busy", {31'b0, bus.busy}, 32'd0);
        chk("abort done", {31'b0, bus.done}, 32'd0);
        chk("abort result", bus.result, 32'd0);
        rst = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) seen = 1'b1;
        end
        chk("abort no done", {31'b0, seen}, 32'd0);
        op("mul after reset", F3_MUL, 32'd3, 32'd4, 32'h0000_000C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit, sitting directly downstream of the register file read port in the execute stage. It consumes the registered `dataA`/`dataB` operands together with the instruction's `funct3`, and computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over a fixed number of cycles. It returns a 32-bit result with a one-cycle `done` pulse; the write-back mux forwards this result as `WB_out`.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `funct3`  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `opA`  in  32  rs1 value (register file `dataA`).
- `opB`  in  32  rs2 value (register file `dataB`).
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse; `result` is valid in this cycle.
- `result`  out  32  registered result; holds its value until the next `done`.

## Operation
- **FSM:** IDLE → CALC → FIX → IDLE.
- **IDLE:**
  - On `start`, capture `funct3`, `opA` and `opB`.
  - Compute operand magnitudes and signs:
    - signed operands: MULH and DIV/REM both operands; MULHSU `opA` only.
    - MUL and unsigned ops: raw values.
  - Clear `cnt` and set `busy`; go to CALC.
- **CALC:** exactly 32 steps, one per cycle, `cnt` counting 0..31; go to FIX after step `cnt`==31.
  - Multiply: shift-add into a 64-bit accumulator on the magnitudes.
  - Divide: restoring; 32-bit quotient and 33-bit partial remainder.
- **FIX:** write `result`, pulse `done`, clear `busy`, return to IDLE.
  - Multiply sign: negate the 64-bit product if the operand signs differ.
    - MUL returns bits [31:0].
    - MULH/MULHSU/MULHU return bits [63:32].
  - Divide sign: quotient is negated if the signs differ; remainder takes the sign of the dividend.
- **Divide by zero:** quotient = 0xFFFFFFFF and remainder = `opA`, signed and unsigned. This overrides sign fix-up.
- **Overflow (DIV 0x80000000 / 0xFFFFFFFF):** quotient = 0x80000000, remainder = 0. This falls out of the magnitude path; no special case is needed.
- **`start` while busy:** ignored; not queued; captured operands are unaffected.
- **`start` during the `done` cycle:** accepted, since the FSM is already in IDLE. This gives back-to-back issue.
- **Reset (`rst`=0 at an edge):**
  - state = IDLE; `busy` = 0, `done` = 0, `result` = 0, `cnt` = 0.
  - Mid-operation reset aborts the operation with no `done`.

## Timing
- `start` is sampled at edge E0. `busy` = 1 from after E0 until after E33.
- CALC occupies edges E1–E32; FIX completes at E33.
- `done` = 1 and `result` is valid for exactly one cycle following E33.
- Latency is 33 cycles for every operation, including special cases; there is no early termination.
- Operands must be stable at E0 only. The register file read is registered, so the issuer asserts `start` one cycle after presenting `addA`/`addB`.
- `busy` and `done` are never high together.

## Structure
- Shared package `riscv_m_pkg`:
  - `funct3` localparams: `F3_MUL` … `F3_REMU`.
  - FSM state typedef: IDLE, CALC, FIX.
  - `MULDIV_LATENCY` = 33.
- Single module, no sub-modules. The multiply and divide datapaths share the 64-bit working register and the step counter.

## Test plan
- MUL, `opA`=0x00000007, `opB`=0xFFFFFFFD → `result`=0xFFFFFFEB, `done` exactly 33 cycles after `start`, `busy` high for E1–E33.
- High products:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide:
  - DIV 0xFFFFFFEC / 0x00000003 → 0xFFFFFFFA.
  - REM same operands → 0xFFFFFFFE.
  - DIVU 0x00000014 / 0x00000003 → 0x00000006; REMU → 0x00000002.
- Corner cases:
  - DIV 0x00000014 / 0 → 0xFFFFFFFF; REM → 0x00000014; DIVU 0xFFFFFFEC / 0 → 0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0x00000000.
- Issue control:
  - `start` pulsed at cycle 5 of an operation with different operands → ignored, original result returned.
  - New `start` in the `done` cycle → second result 33 cycles later.
- Reset:
  - `rst`=0 at cycle 10 of a DIV → `busy`=0, `result`=0, no `done`.
  - Following MUL 3×4 → 0x0000000C with correct latency.
